// File: rtl/cpu_pkg.sv
// Shared CPU encodings: ALU control codes, main-decoder ALUOp values and
// R-type funct fields used by the ID/EX stage and the ALU.
package cpu_pkg;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_RTYPE = 2'b10,
    ALUOP_OR    = 2'b11
  } aluop_e;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  typedef struct packed {
    logic [2:0] alu_control;
    logic       illegal;
  } alu_dec_t;

endpackage

// File: rtl/forward_mux.sv
// Per-operand bypass select: EX/MEM beats MEM/WB, and register 0 never bypasses.
module forward_mux #(
  parameter int W = 32
) (
  input  logic [4:0]   src,
  input  logic [W-1:0] reg_data,
  input  logic         exmem_reg_write,
  input  logic [4:0]   exmem_rd,
  input  logic [W-1:0] exmem_result,
  input  logic         memwb_reg_write,
  input  logic [4:0]   memwb_rd,
  input  logic [W-1:0] memwb_result,
  output logic [W-1:0] fwd_data
);

  logic hit_exmem;
  logic hit_memwb;

  always_comb begin
    hit_exmem = exmem_reg_write && (exmem_rd != 5'd0) && (exmem_rd == src);
    hit_memwb = memwb_reg_write && (memwb_rd != 5'd0) && (memwb_rd == src);
    fwd_data  = reg_data;
    if (hit_exmem) begin
      fwd_data = exmem_result;
    end else if (hit_memwb) begin
      fwd_data = memwb_result;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: latches decoded operands and controls, decodes the
// ALU control code at load time, and forwards EX/MEM and MEM/WB results.
module id_ex_stage
  import cpu_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         stall,
  input  logic         flush,
  input  logic         id_valid,
  input  logic [W-1:0] id_rs_data,
  input  logic [W-1:0] id_rt_data,
  input  logic [W-1:0] id_imm,
  input  logic [4:0]   id_rs,
  input  logic [4:0]   id_rt,
  input  logic [4:0]   id_rd,
  input  logic [1:0]   id_alu_op,
  input  logic [5:0]   id_funct,
  input  logic         id_alu_src,
  input  logic         id_reg_dst,
  input  logic         id_reg_write,
  input  logic         id_mem_read,
  input  logic         id_mem_write,
  input  logic         id_mem_to_reg,
  input  logic         exmem_reg_write,
  input  logic [4:0]   exmem_rd,
  input  logic [W-1:0] exmem_result,
  input  logic         memwb_reg_write,
  input  logic [4:0]   memwb_rd,
  input  logic [W-1:0] memwb_result,
  output logic         ex_valid,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [2:0]   alu_control,
  output logic [W-1:0] ex_store_data,
  output logic [4:0]   ex_dest,
  output logic         ex_reg_write,
  output logic         ex_mem_read,
  output logic         ex_mem_write,
  output logic         ex_mem_to_reg,
  output logic         ex_illegal
);

  function automatic alu_dec_t alu_decode(input logic [1:0] op, input logic [5:0] funct);
    alu_dec_t d;
    d.alu_control = ALU_ADD;
    d.illegal     = 1'b0;
    case (aluop_e'(op))
      ALUOP_ADD: d.alu_control = ALU_ADD;
      ALUOP_SUB: d.alu_control = ALU_SUB;
      ALUOP_OR:  d.alu_control = ALU_OR;
      default: begin
        case (funct)
          FUNCT_ADD: d.alu_control = ALU_ADD;
          FUNCT_SUB: d.alu_control = ALU_SUB;
          FUNCT_AND: d.alu_control = ALU_AND;
          FUNCT_OR:  d.alu_control = ALU_OR;
          FUNCT_SLT: d.alu_control = ALU_SLT;
          default:   d.illegal     = 1'b1;
        endcase
      end
    endcase
    return d;
  endfunction

  logic         valid_q, valid_d;
  logic [W-1:0] rs_data_q, rs_data_d;
  logic [W-1:0] rt_data_q, rt_data_d;
  logic [W-1:0] imm_q, imm_d;
  logic [4:0]   rs_q, rs_d;
  logic [4:0]   rt_q, rt_d;
  logic [4:0]   dest_q, dest_d;
  logic [2:0]   alu_control_q, alu_control_d;
  logic         alu_src_q, alu_src_d;
  logic         reg_write_q, reg_write_d;
  logic         mem_read_q, mem_read_d;
  logic         mem_write_q, mem_write_d;
  logic         mem_to_reg_q, mem_to_reg_d;
  logic         illegal_q, illegal_d;

  alu_dec_t     dec;
  logic [W-1:0] fwd_rs;
  logic [W-1:0] fwd_rt;

  // Edge action priority: flush (bubble, everything zeroed) over stall (hold) over load.
  always_comb begin
    dec           = alu_decode(id_alu_op, id_funct);
    valid_d       = valid_q;
    rs_data_d     = rs_data_q;
    rt_data_d     = rt_data_q;
    imm_d         = imm_q;
    rs_d          = rs_q;
    rt_d          = rt_q;
    dest_d        = dest_q;
    alu_control_d = alu_control_q;
    alu_src_d     = alu_src_q;
    reg_write_d   = reg_write_q;
    mem_read_d    = mem_read_q;
    mem_write_d   = mem_write_q;
    mem_to_reg_d  = mem_to_reg_q;
    illegal_d     = illegal_q;
    if (flush) begin
      valid_d       = 1'b0;
      rs_data_d     = '0;
      rt_data_d     = '0;
      imm_d         = '0;
      rs_d          = 5'd0;
      rt_d          = 5'd0;
      dest_d        = 5'd0;
      alu_control_d = 3'b000;
      alu_src_d     = 1'b0;
      reg_write_d   = 1'b0;
      mem_read_d    = 1'b0;
      mem_write_d   = 1'b0;
      mem_to_reg_d  = 1'b0;
      illegal_d     = 1'b0;
    end else if (!stall) begin
      valid_d       = id_valid;
      rs_data_d     = id_rs_data;
      rt_data_d     = id_rt_data;
      imm_d         = id_imm;
      rs_d          = id_rs;
      rt_d          = id_rt;
      dest_d        = id_reg_dst ? id_rd : id_rt;
      alu_control_d = dec.alu_control;
      alu_src_d     = id_alu_src;
      // An unsupported funct must not commit architectural state.
      reg_write_d   = id_reg_write && !dec.illegal;
      mem_read_d    = id_mem_read;
      mem_write_d   = id_mem_write && !dec.illegal;
      mem_to_reg_d  = id_mem_to_reg;
      illegal_d     = dec.illegal;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q       <= 1'b0;
      rs_data_q     <= '0;
      rt_data_q     <= '0;
      imm_q         <= '0;
      rs_q          <= 5'd0;
      rt_q          <= 5'd0;
      dest_q        <= 5'd0;
      alu_control_q <= 3'b000;
      alu_src_q     <= 1'b0;
      reg_write_q   <= 1'b0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_to_reg_q  <= 1'b0;
      illegal_q     <= 1'b0;
    end else begin
      valid_q       <= valid_d;
      rs_data_q     <= rs_data_d;
      rt_data_q     <= rt_data_d;
      imm_q         <= imm_d;
      rs_q          <= rs_d;
      rt_q          <= rt_d;
      dest_q        <= dest_d;
      alu_control_q <= alu_control_d;
      alu_src_q     <= alu_src_d;
      reg_write_q   <= reg_write_d;
      mem_read_q    <= mem_read_d;
      mem_write_q   <= mem_write_d;
      mem_to_reg_q  <= mem_to_reg_d;
      illegal_q     <= illegal_d;
    end
  end

  forward_mux #(.W(W)) u_fwd_rs (
    .src             (rs_q),
    .reg_data        (rs_data_q),
    .exmem_reg_write (exmem_reg_write),
    .exmem_rd        (exmem_rd),
    .exmem_result    (exmem_result),
    .memwb_reg_write (memwb_reg_write),
    .memwb_rd        (memwb_rd),
    .memwb_result    (memwb_result),
    .fwd_data        (fwd_rs)
  );

  forward_mux #(.W(W)) u_fwd_rt (
    .src             (rt_q),
    .reg_data        (rt_data_q),
    .exmem_reg_write (exmem_reg_write),
    .exmem_rd        (exmem_rd),
    .exmem_result    (exmem_result),
    .memwb_reg_write (memwb_reg_write),
    .memwb_rd        (memwb_rd),
    .memwb_result    (memwb_result),
    .fwd_data        (fwd_rt)
  );

  always_comb begin
    ex_valid      = valid_q;
    alu_a         = fwd_rs;
    alu_b         = alu_src_q ? imm_q : fwd_rt;
    alu_control   = alu_control_q;
    ex_store_data = fwd_rt;
    ex_dest       = dest_q;
    ex_reg_write  = reg_write_q;
    ex_mem_read   = mem_read_q;
    ex_mem_write  = mem_write_q;
    ex_mem_to_reg = mem_to_reg_q;
    ex_illegal    = illegal_q;
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, decode table, forwarding priority,
// register-0 guard, stall/flush behaviour and illegal funct handling.
module tb_id_ex_stage;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, stall, flush, id_valid;
  logic [W-1:0] id_rs_data, id_rt_data, id_imm;
  logic [4:0]   id_rs, id_rt, id_rd;
  logic [1:0]   id_alu_op;
  logic [5:0]   id_funct;
  logic         id_alu_src, id_reg_dst, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
  logic         exmem_reg_write, memwb_reg_write;
  logic [4:0]   exmem_rd, memwb_rd;
  logic [W-1:0] exmem_result, memwb_result;
  logic         ex_valid;
  logic [W-1:0] alu_a, alu_b, ex_store_data;
  logic [2:0]   alu_control;
  logic [4:0]   ex_dest;
  logic         ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_illegal;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];

  id_ex_stage #(.W(W)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_alu_op(id_alu_op), .id_funct(id_funct),
    .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .ex_valid(ex_valid), .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
    .ex_store_data(ex_store_data), .ex_dest(ex_dest), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
    .ex_illegal(ex_illegal)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h want=0x%08h", tag, got, exp);
    end
  endtask

  // advance one edge and settle just after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    stall = 0; flush = 0; id_valid = 0;
    id_rs_data = '0; id_rt_data = '0; id_imm = '0;
    id_rs = 0; id_rt = 0; id_rd = 0; id_alu_op = 2'b00; id_funct = 6'b0;
    id_alu_src = 0; id_reg_dst = 0; id_reg_write = 0;
    id_mem_read = 0; id_mem_write = 0; id_mem_to_reg = 0;
    exmem_reg_write = 0; exmem_rd = 0; exmem_result = '0;
    memwb_reg_write = 0; memwb_rd = 0; memwb_result = '0;
  endtask

  task automatic drive_instr(input logic [1:0] op, input logic [5:0] funct,
                             input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                             input logic [W-1:0] rs_data, input logic [W-1:0] rt_data,
                             input logic [W-1:0] imm, input logic alu_src, input logic reg_dst,
                             input logic reg_write);
    id_valid = 1; id_alu_op = op; id_funct = funct;
    id_rs = rs; id_rt = rt; id_rd = rd;
    id_rs_data = rs_data; id_rt_data = rt_data; id_imm = imm;
    id_alu_src = alu_src; id_reg_dst = reg_dst; id_reg_write = reg_write;
  endtask

  logic [1:0] tbl_op    [8] = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10};
  logic [5:0] tbl_funct [8] = '{6'b000111, 6'b100100, 6'b000000, 6'b100000,
                                6'b100010, 6'b100100, 6'b100101, 6'b101010};
  logic [2:0] tbl_code  [8] = '{3'b010, 3'b110, 3'b001, 3'b010,
                                3'b110, 3'b000, 3'b001, 3'b111};

  initial begin
    clear_inputs();
    rst = 1;
    id_valid = 1;
    id_reg_write = 1;
    id_mem_write = 1;
    step();
    step();
    check_eq("rst_valid", W'(ex_valid), 0);
    check_eq("rst_ctrl", W'(alu_control), 0);
    check_eq("rst_regw", W'(ex_reg_write), 0);
    check_eq("rst_memw", W'(ex_mem_write), 0);
    check_eq("rst_alu_a", alu_a, 0);
    rst = 0;
    clear_inputs();

    // R-type slt
    drive_instr(2'b10, 6'b101010, 5'd1, 5'd2, 5'd7, 32'd5, 32'd9, 32'h0, 0, 1, 1);
    step();
    check_eq("slt_ctrl", W'(alu_control), 3'b111);
    check_eq("slt_a", alu_a, 32'd5);
    check_eq("slt_b", alu_b, 32'd9);
    check_eq("slt_dest", W'(ex_dest), 5'd7);
    check_eq("slt_valid", W'(ex_valid), 1);

    // ALU control decode table, expected codes via scoreboard queue
    for (int i = 0; i < 8; i++) begin
      drive_instr(tbl_op[i], tbl_funct[i], 5'd1, 5'd2, 5'd3, 32'd1, 32'd2, 32'd0, 0, 1, 1);
      exp_q.push_back(W'(tbl_code[i]));
      step();
      check_eq($sformatf("dec%0d", i), W'(alu_control), exp_q.pop_front());
    end

    // forwarding: rs=3, rt=4, immediate operand selected
    drive_instr(2'b00, 6'b0, 5'd3, 5'd4, 5'd9, 32'h1234, 32'h5678, 32'h40, 1, 0, 1);
    id_mem_read = 1; id_mem_to_reg = 1;
    step();
    check_eq("ld_dest_rt", W'(ex_dest), 5'd4);
    check_eq("ld_memrd", W'(ex_mem_read), 1);
    check_eq("ld_m2r", W'(ex_mem_to_reg), 1);
    exmem_reg_write = 1; exmem_rd = 3; exmem_result = 32'hAAAA_0000;
    memwb_reg_write = 1; memwb_rd = 3; memwb_result = 32'h1111_1111;
    #1;
    check_eq("fwd_prio", alu_a, 32'hAAAA_0000);
    check_eq("fwd_rt_none", ex_store_data, 32'h5678);
    check_eq("fwd_imm_b", alu_b, 32'h40);
    exmem_reg_write = 0;
    #1;
    check_eq("fwd_memwb", alu_a, 32'h1111_1111);
    memwb_rd = 4;
    #1;
    check_eq("fwd_rs_reg", alu_a, 32'h1234);
    check_eq("fwd_rt_memwb", ex_store_data, 32'h1111_1111);
    check_eq("fwd_imm_b2", alu_b, 32'h40);
    exmem_reg_write = 1; exmem_rd = 4; exmem_result = 32'hBEEF_0001;
    #1;
    check_eq("fwd_rt_exmem", ex_store_data, 32'hBEEF_0001);
    clear_inputs();

    // register 0 is never forwarded
    drive_instr(2'b00, 6'b0, 5'd0, 5'd0, 5'd1, 32'h0, 32'h0, 32'h0, 0, 1, 1);
    step();
    exmem_reg_write = 1; exmem_rd = 0; exmem_result = 32'hFFFF_FFFF;
    memwb_reg_write = 1; memwb_rd = 0; memwb_result = 32'hEEEE_EEEE;
    #1;
    check_eq("r0_a", alu_a, 0);
    check_eq("r0_b", alu_b, 0);
    clear_inputs();

    // stall holds, then stall+flush loads a bubble
    drive_instr(2'b00, 6'b0, 5'd1, 5'd2, 5'd5, 32'h10, 32'h20, 32'h0, 0, 0, 1);
    step();
    check_eq("add_ctrl", W'(alu_control), 3'b010);
    check_eq("add_dest", W'(ex_dest), 5'd2);
    stall = 1;
    for (int c = 0; c < 3; c++) begin
      drive_instr(2'b01, 6'b0, 5'd6, 5'd7, 5'd8, $urandom_range(100, 999), 32'h99, 32'h5, 1, 1, 0);
      step();
      check_eq($sformatf("stall%0d_a", c), alu_a, 32'h10);
      check_eq($sformatf("stall%0d_b", c), alu_b, 32'h20);
      check_eq($sformatf("stall%0d_ctrl", c), W'(alu_control), 3'b010);
      check_eq($sformatf("stall%0d_dest", c), W'(ex_dest), 5'd2);
      check_eq($sformatf("stall%0d_regw", c), W'(ex_reg_write), 1);
    end
    flush = 1;
    step();
    check_eq("flush_valid", W'(ex_valid), 0);
    check_eq("flush_regw", W'(ex_reg_write), 0);
    check_eq("flush_a", alu_a, 0);
    clear_inputs();

    // illegal funct
    drive_instr(2'b10, 6'b000111, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 32'h0, 0, 1, 1);
    id_mem_write = 1;
    step();
    check_eq("ill_flag", W'(ex_illegal), 1);
    check_eq("ill_ctrl", W'(alu_control), 3'b010);
    check_eq("ill_regw", W'(ex_reg_write), 0);
    check_eq("ill_memw", W'(ex_mem_write), 0);
    check_eq("ill_valid", W'(ex_valid), 1);
    clear_inputs();

    // reset wins over stall and flush
    drive_instr(2'b11, 6'b0, 5'd1, 5'd2, 5'd3, 32'h7, 32'h8, 32'h0, 0, 1, 1);
    step();
    check_eq("pre_rst_ctrl", W'(alu_control), 3'b001);
    stall = 1; rst = 1;
    step();
    check_eq("rst_stall_valid", W'(ex_valid), 0);
    check_eq("rst_stall_ctrl", W'(alu_control), 0);
    rst = 0; stall = 0;
    step();
    flush = 1; rst = 1;
    step();
    check_eq("rst_flush_a", alu_a, 0);
    rst = 0; flush = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
